// File: rtl/accum_pkg.sv
// ---------------------------------------------------------------------------
// accum_pkg
// Shared types and helpers for the sequence accumulator.
//   mode_t   : fold operation selected at stream start
//   state_t  : controller states (two-bit register)
//   identity : starting accumulator value for a given operation
// ---------------------------------------------------------------------------
package accum_pkg;

  typedef enum logic [1:0] {
    M_SUM = 2'd0,
    M_MIN = 2'd1,
    M_MAX = 2'd2,
    M_XOR = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Identity element of each fold, returned 64 bits wide so one function
  // serves every data width; callers keep the low w bits (w <= 64).
  // MIN starts from all-ones so the first element always wins the compare.
  function automatic logic [63:0] identity(input mode_t m, input int unsigned w);
    logic [63:0] ones;
    ones = ~64'd0;
    if (m == M_MIN) begin
      return ones >> (64 - w);
    end
    return 64'd0;
  endfunction

endpackage

// File: rtl/accum_alu.sv
// ---------------------------------------------------------------------------
// accum_alu
// Combinational fold step: acc_next = op(acc, in_a).
//   mode     in  fold operation
//   acc      in  current accumulator value
//   in_a     in  element being folded in
//   acc_next out updated accumulator value
//   carry    out SUM carried past W bits (always 0 for MIN/MAX/XOR)
// SATURATE=1 clamps an overflowing SUM to all-ones, SATURATE=0 wraps.
// ---------------------------------------------------------------------------
module accum_alu
  import accum_pkg::*;
#(
  parameter int W        = 8,
  parameter int SATURATE = 1
) (
  input  mode_t          mode,
  input  logic [W-1:0]   acc,
  input  logic [W-1:0]   in_a,
  output logic [W-1:0]   acc_next,
  output logic           carry
);

  logic [W:0] sum;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, in_a};
    acc_next = acc;
    carry    = 1'b0;
    unique case (mode)
      M_SUM: begin
        carry = sum[W];
        // Once clamped at all-ones, any further non-zero add carries again,
        // so the result stays pinned without extra state.
        if (SATURATE != 0 && sum[W]) begin
          acc_next = '1;
        end else begin
          acc_next = sum[W-1:0];
        end
      end
      M_MIN: acc_next = (in_a < acc) ? in_a : acc;
      M_MAX: acc_next = (in_a > acc) ? in_a : acc;
      M_XOR: acc_next = acc ^ in_a;
      default: acc_next = acc;
    endcase
  end

endmodule

// File: rtl/accum_seq.sv
// ---------------------------------------------------------------------------
// accum_seq
// go_l-started sequence accumulator. Folds a stream of qualified words into
// a SUM / MIN / MAX / XOR result; the stream ends on a zero word or after
// MAXN non-zero elements. done holds until ack_l or a new go_l.
//   ck       in  clock, rising edge
//   reset_l  in  asynchronous active-low reset
//   go_l     in  active-low start, sampled only in IDLE and DONE
//   mode     in  0 SUM, 1 MIN, 2 MAX, 3 XOR (latched at start)
//   inA      in  data word
//   in_valid in  inA qualifier
//   ack_l    in  active-low acknowledge of done
//   busy     out stream in progress (RUN)
//   done     out result ready (DONE)
//   result   out accumulator value
//   count    out non-terminator elements accepted
//   ovf      out sticky SUM overflow for this stream
//   trunc    out stream ended by the MAXN limit
//
// Input handshake: inA is taken on every rising edge where in_valid=1 and
// the block is in RUN. There is no ready/back-pressure; the source must not
// present words outside RUN (they are simply dropped). Outputs are decoded
// from registers only.
// ---------------------------------------------------------------------------
module accum_seq
  import accum_pkg::*;
#(
  parameter int W        = 8,
  parameter int CW       = 8,
  parameter int MAXN     = 255,  // 1 .. 2^CW-1
  parameter int SATURATE = 1
) (
  input  logic          ck,
  input  logic          reset_l,
  input  logic          go_l,
  input  logic [1:0]    mode,
  input  logic [W-1:0]  inA,
  input  logic          in_valid,
  input  logic          ack_l,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic [CW-1:0] count,
  output logic          ovf,
  output logic          trunc
);

  state_t        state_q;
  mode_t         mode_q;
  logic [W-1:0]  alu_next;
  logic          alu_carry;
  logic [63:0]   ident_wide;
  logic [CW-1:0] count_inc;
  logic          start;
  logic          take_elem;
  logic          take_term;
  logic          limit_hit;

  accum_alu #(
    .W        (W),
    .SATURATE (SATURATE)
  ) u_alu (
    .mode     (mode_q),
    .acc      (result),
    .in_a     (inA),
    .acc_next (alu_next),
    .carry    (alu_carry)
  );

  // Identity is computed from the live mode input because it is loaded on
  // the same edge that latches mode.
  assign ident_wide = identity(mode_t'(mode), W);

  assign start     = ((state_q == S_IDLE) || (state_q == S_DONE)) && !go_l;
  assign take_elem = (state_q == S_RUN) && in_valid && (inA != '0);
  assign take_term = (state_q == S_RUN) && in_valid && (inA == '0);
  assign count_inc = count + 1'b1;
  assign limit_hit = (count_inc == CW'(MAXN));

  always_ff @(posedge ck or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= S_IDLE;
      mode_q  <= M_SUM;
      result  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      trunc   <= 1'b0;
    end else begin
      // A start from DONE implies the acknowledge, so IDLE and DONE share it.
      if (start) begin
        state_q <= S_RUN;
        mode_q  <= mode_t'(mode);
        result  <= ident_wide[W-1:0];
        count   <= '0;
        ovf     <= 1'b0;
        trunc   <= 1'b0;
      end else begin
        unique case (state_q)
          S_RUN: begin
            if (take_term) begin
              state_q <= S_DONE;
            end else if (take_elem) begin
              result <= alu_next;
              count  <= count_inc;
              ovf    <= ovf | alu_carry;
              if (limit_hit) begin
                state_q <= S_DONE;
                trunc   <= 1'b1;
              end
            end
          end
          S_DONE: begin
            if (!ack_l) begin
              state_q <= S_IDLE;
            end
          end
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_accum_seq.sv
// ---------------------------------------------------------------------------
// tb_accum_seq
// Three accum_seq instances share one stimulus stream:
//   0: MAXN=255 SATURATE=1   1: MAXN=255 SATURATE=0   2: MAXN=4 SATURATE=1
// A stream-level reference model recomputes the expected outputs from the
// prefix of words driven so far, after every clock.
// ---------------------------------------------------------------------------
module tb_accum_seq;

  // ---------------- clock / reset ----------------
  logic       ck = 1'b0;
  logic       reset_l = 1'b0;
  logic       go_l = 1'b1;
  logic       ack_l = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] inA = 8'd0;

  always #5 ck = ~ck;

  logic       busy  [3];
  logic       done  [3];
  logic       ovf   [3];
  logic       trunc [3];
  logic [7:0] result[3];
  logic [7:0] count [3];

  accum_seq #(.W(8), .CW(8), .MAXN(255), .SATURATE(1)) u_dut0 (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .mode(mode), .inA(inA),
    .in_valid(in_valid), .ack_l(ack_l), .busy(busy[0]), .done(done[0]),
    .result(result[0]), .count(count[0]), .ovf(ovf[0]), .trunc(trunc[0]));

  accum_seq #(.W(8), .CW(8), .MAXN(255), .SATURATE(0)) u_dut1 (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .mode(mode), .inA(inA),
    .in_valid(in_valid), .ack_l(ack_l), .busy(busy[1]), .done(done[1]),
    .result(result[1]), .count(count[1]), .ovf(ovf[1]), .trunc(trunc[1]));

  accum_seq #(.W(8), .CW(8), .MAXN(4), .SATURATE(1)) u_dut2 (
    .ck(ck), .reset_l(reset_l), .go_l(go_l), .mode(mode), .inA(inA),
    .in_valid(in_valid), .ack_l(ack_l), .busy(busy[2]), .done(done[2]),
    .result(result[2]), .count(count[2]), .ovf(ovf[2]), .trunc(trunc[2]));

  int maxn_c[3] = '{255, 255, 4};
  bit sat_c [3] = '{1'b1, 1'b0, 1'b1};

  // ---------------- stream storage / scoreboard ----------------
  bit         s_valid[$];
  logic [7:0] s_data [$];
  logic [7:0] exp_q  [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic check_eq(input string tag, input int inst,
                          input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%0d expected=%0d at %0t", tag, inst, got, exp, $time);
    end
  endtask

  task automatic push(input bit v, input logic [7:0] d);
    s_valid.push_back(v);
    s_data.push_back(d);
  endtask

  task automatic clear_stream();
    s_valid.delete();
    s_data.delete();
  endtask

  // Reference: fold the first 'upto' driven cycles of the stream.
  task automatic model(input int inst, input int upto, input int m,
                       output logic [7:0] r, output int cnt, output bit ov,
                       output bit tr, output bit ended);
    int acc;
    int dd;
    acc   = (m == 1) ? 255 : 0;
    cnt   = 0;
    ov    = 0;
    tr    = 0;
    ended = 0;
    for (int j = 0; j < upto && !ended; j++) begin
      if (s_valid[j]) begin
        dd = int'(s_data[j]);
        if (dd == 0) begin
          ended = 1;
        end else begin
          case (m)
            0: begin
              acc = acc + dd;
              if (acc > 255) begin
                ov  = 1;
                acc = sat_c[inst] ? 255 : acc - 256;
              end
            end
            1: if (dd < acc) acc = dd;
            2: if (dd > acc) acc = dd;
            default: acc = acc ^ dd;
          endcase
          cnt++;
          if (cnt == maxn_c[inst]) begin
            ended = 1;
            tr    = 1;
          end
        end
      end
    end
    r = 8'(acc);
  endtask

  task automatic check_all(input int upto, input int m);
    logic [7:0] r;
    int cnt;
    bit ov, tr, ended;
    for (int k = 0; k < 3; k++) begin
      model(k, upto, m, r, cnt, ov, tr, ended);
      check_eq("done",   k, 32'(done[k]),   32'(ended));
      check_eq("busy",   k, 32'(busy[k]),   32'(!ended));
      check_eq("result", k, 32'(result[k]), 32'(r));
      check_eq("count",  k, 32'(count[k]),  32'(cnt));
      check_eq("ovf",    k, 32'(ovf[k]),    32'(ov));
      check_eq("trunc",  k, 32'(trunc[k]),  32'(tr));
      check_eq("excl",   k, 32'(busy[k] & done[k]), 32'd0);
    end
  endtask

  // Start a stream (optionally with ack_l low on the start cycle) and drive
  // every stored cycle, checking after each edge.
  task automatic run_stream(input int m, input bit ack_on_start);
    mode  = 2'(m);
    go_l  = 1'b0;
    ack_l = ack_on_start ? 1'b0 : 1'b1;
    step();
    go_l  = 1'b1;
    ack_l = 1'b1;
    check_all(0, m);
    for (int i = 0; i < s_valid.size(); i++) begin
      in_valid = s_valid[i];
      inA      = s_data[i];
      mode     = 2'($urandom_range(0, 3));  // must be ignored after start
      step();
      check_all(i + 1, m);
    end
    in_valid = 1'b0;
    inA      = 8'($urandom_range(0, 255));
  endtask

  // Acknowledge; results must hold in IDLE.
  task automatic ack_and_hold(input int m);
    logic [7:0] r;
    int cnt;
    bit ov, tr, ended;
    for (int k = 0; k < 3; k++) begin
      model(k, s_valid.size(), m, r, cnt, ov, tr, ended);
      exp_q.push_back(r);
    end
    ack_l = 1'b0;
    step();
    ack_l = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check_eq("idle_done", k, 32'(done[k]), 32'd0);
      check_eq("idle_busy", k, 32'(busy[k]), 32'd0);
      check_eq("idle_hold", k, 32'(result[k]), 32'(exp_q.pop_front()));
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int m;
    int len;
    step();
    step();
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_result", k, 32'(result[k]), 32'd0);
      check_eq("rst_count",  k, 32'(count[k]),  32'd0);
      check_eq("rst_done",   k, 32'(done[k]),   32'd0);
      check_eq("rst_busy",   k, 32'(busy[k]),   32'd0);
      check_eq("rst_flags",  k, 32'({ovf[k], trunc[k]}), 32'd0);
    end
    reset_l = 1'b1;
    step();

    // SUM 3,5,7,0
    clear_stream();
    push(1, 3); push(1, 5); push(1, 7); push(1, 0);
    run_stream(0, 0);
    ack_and_hold(0);

    // SUM overflow 200,100,0 (saturating vs wrapping instance)
    clear_stream();
    push(1, 200); push(1, 100); push(1, 0);
    run_stream(0, 0);
    ack_and_hold(0);

    // MIN / MAX on 9,4,250,0
    clear_stream();
    push(1, 9); push(1, 4); push(1, 250); push(1, 0);
    run_stream(1, 0);
    ack_and_hold(1);
    run_stream(2, 0);
    ack_and_hold(2);

    // MIN empty stream
    clear_stream();
    push(1, 0);
    run_stream(1, 0);
    ack_and_hold(1);

    // Valid gaps carrying zero data
    clear_stream();
    push(1, 6); push(0, 0); push(0, 0); push(0, 0); push(1, 2); push(1, 0);
    run_stream(0, 0);
    ack_and_hold(0);

    // Limit: instance 2 (MAXN=4) truncates, others end on the zero
    clear_stream();
    push(1, 1); push(1, 1); push(1, 1); push(1, 1); push(1, 9); push(1, 0);
    run_stream(0, 0);
    // Restart straight from DONE with ack_l low on the same cycle
    clear_stream();
    push(1, 7); push(1, 0);
    run_stream(3, 1);
    ack_and_hold(3);

    // Reset mid-RUN after 10,20
    clear_stream();
    push(1, 10); push(1, 20);
    run_stream(0, 0);
    reset_l = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check_eq("arst_result", k, 32'(result[k]), 32'd0);
      check_eq("arst_count",  k, 32'(count[k]),  32'd0);
      check_eq("arst_done",   k, 32'(done[k]),   32'd0);
      check_eq("arst_busy",   k, 32'(busy[k]),   32'd0);
    end
    step();
    reset_l = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      check_eq("post_rst_idle", k, 32'(busy[k] | done[k]), 32'd0);
    end

    // Randomised streams; every stream ends with a valid terminator
    for (int n = 0; n < 40; n++) begin
      clear_stream();
      m   = $urandom_range(0, 3);
      len = $urandom_range(0, 10);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) push(0, 8'($urandom_range(0, 255)));
        else                           push(1, 8'($urandom_range(1, 255)));
      end
      push(1, 0);
      run_stream(m, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) ack_and_hold(m);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends on its own.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL timeout got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
